pipeline_skid_buffer: RTL and testbench

//  Parametrised elastic stage register between pipeline stages. Replaces plain flop stages.

---
 rtl/pipeline_skid_buffer_pkg.sv | 21 ++
 rtl/pipeline_skid_buffer_if.sv | 28 ++
 rtl/pipeline_skid_buffer_sat_counter.sv | 36 +++
 rtl/pipeline_skid_buffer.sv | 150 +++++++++++++++
 tb/tb_pipeline_skid_buffer.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/pipeline_skid_buffer_pkg.sv
// Shared definitions for the pipeline buffer family: state encodings and small helpers.
// Latency: n/a (package, no logic of its own).
// Backpressure: n/a.
//
// State encodings are shared by every buffer that tracks an EMPTY/BUSY/FULL occupancy.
// The fourth code of the 2-bit state (2'd3) is illegal; every user must steer it
// back to ST_EMPTY so an upset flop cannot wedge the pipeline.
package pipeline_skid_buffer_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,  // no stored entry
        ST_BUSY  = 2'd1,  // main register holds the head entry
        ST_FULL  = 2'd2   // main holds the head, skid holds the next entry
    } state_e;

    // A handshake transfer happens on a cycle where both sides agree.
    function automatic logic hs_fire(input logic vld, input logic rdy);
        return vld & rdy;
    endfunction

endpackage : pipeline_skid_buffer_pkg

// File: rtl/pipeline_skid_buffer_if.sv
// Valid/ready channel carrying one DATA_WIDTH payload per transfer.
// Latency: none (wires only).
// Backpressure: ready from the receiver; a transfer happens when valid & ready.
//
// Modports:
//   master - drives valid/data, samples ready (the producing side)
//   slave  - samples valid/data, drives ready (the consuming side)
interface pipeline_skid_buffer_if #(
    parameter int unsigned DATA_WIDTH = 64
);

    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );

endinterface : pipeline_skid_buffer_if

// File: rtl/pipeline_skid_buffer_sat_counter.sv
// Saturating up-counter shared by the pipeline buffers for stall statistics.
// Latency: count reflects an inc on the following clock edge.
// Backpressure: none; counts every enabled cycle and sticks at all-ones.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-low reset, clears count
//   inc    add one this cycle (ignored once saturated)
//   clear  synchronous clear, wins over inc
//   count  current value
module sat_counter #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    input  logic                 clear,
    output logic [CNT_WIDTH-1:0] count
);

    logic at_max;

    // Saturation guard: once every bit is set the counter never wraps.
    assign at_max = &count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && !at_max) begin
            count <= count + 1'b1;
        end
    end

endmodule : sat_counter

// File: rtl/pipeline_skid_buffer.sv
// Elastic two-entry (main + skid) stage register with valid/ready on both sides and sync flush.
// Latency: 1 cycle from in_fire to out_valid; sustains one transfer per cycle.
// Backpressure: in_ready is decoded from state flops only (low only when FULL), no comb path from out_ready.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   flush        synchronous flush, empties both entries, beats every handshake
//   in_if        slave side of the upstream channel (valid/data in, ready out)
//   out_if       master side of the downstream channel; data comes straight from main
//   stall_count  cycles with out_valid & !out_ready & !flush, saturating;
//                exists only when PIPE_SKID_STATS_EN is defined
//
// Build option: PIPE_SKID_STATS_EN adds the stall counter; the datapath is the same either way.
module pipeline_skid_buffer
    import pipeline_skid_buffer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    pipeline_skid_buffer_if.slave  in_if,
    pipeline_skid_buffer_if.master out_if
`ifdef PIPE_SKID_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]  stall_count
`endif
);

    state_e                state_q;
    state_e                state_d;
    logic [DATA_WIDTH-1:0] main_q;
    logic [DATA_WIDTH-1:0] main_d;
    logic [DATA_WIDTH-1:0] skid_q;
    logic [DATA_WIDTH-1:0] skid_d;

    logic out_valid;
    logic in_ready;
    logic in_fire;
    logic out_fire;

    // Both handshake outputs come from the state register alone, which is what
    // breaks the out_ready -> in_ready timing path between pipeline stages.
    assign out_valid = (state_q != ST_EMPTY);
    assign in_ready  = (state_q != ST_FULL);

    assign in_fire  = hs_fire(in_if.valid, in_ready);
    assign out_fire = hs_fire(out_valid, out_if.ready);

    assign in_if.ready  = in_ready;
    assign out_if.valid = out_valid;
    assign out_if.data  = main_q;

    // ------------------------------------------------------------------
    // State and storage registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and storage update
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (flush) begin
            // A same-cycle in_fire is swallowed here; a same-cycle out_fire has
            // already handed main_q to downstream, so dropping it is safe.
            state_d = ST_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d = ST_BUSY;
                        main_d  = in_if.data;
                    end
                end

                ST_BUSY: begin
                    if (in_fire && out_fire) begin
                        // Head leaves while the next entry arrives: refill main
                        // directly, skid stays unused at full throughput.
                        main_d = in_if.data;
                    end else if (in_fire) begin
                        // Downstream stalled: park the newcomer behind main.
                        state_d = ST_FULL;
                        skid_d  = in_if.data;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end

                ST_FULL: begin
                    // in_ready is low here, so only the drain side can move.
                    // The skid entry is promoted, never bypassed, keeping FIFO order.
                    if (out_fire) begin
                        state_d = ST_BUSY;
                        main_d  = skid_q;
                    end
                end

                default: begin
                    // Illegal encoding: discard contents and restart empty.
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Optional stall statistics
    // ------------------------------------------------------------------
`ifdef PIPE_SKID_STATS_EN
    logic stall_inc;

    // A flush cycle is not counted as a stall even if downstream is not ready.
    assign stall_inc = out_valid & ~out_if.ready & ~flush;

    // Only reset clears the statistic, so the synchronous clear is tied off.
    sat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .clear (1'b0),
        .count (stall_count)
    );
`else
    // Without statistics CNT_WIDTH sizes nothing; a zero width is simply ignored.
    if (CNT_WIDTH == 0) begin : g_no_stats
    end
`endif

endmodule : pipeline_skid_buffer

// File: tb/tb_pipeline_skid_buffer.sv
// Directed bench for pipeline_skid_buffer: vector table plus hand sequences for reset/stats.
// Latency: checks outputs 1 time unit after each rising edge.
// Backpressure: driven explicitly per vector through out_ready.
module tb_pipeline_skid_buffer;

    localparam int unsigned DW = 64;
`ifdef PIPE_SKID_STATS_EN
    localparam int unsigned CW = 3;
`else
    localparam int unsigned CW = 16;
`endif

    logic clk;
    logic rst;
    logic flush;

    pipeline_skid_buffer_if #(.DATA_WIDTH(DW)) in_if ();
    pipeline_skid_buffer_if #(.DATA_WIDTH(DW)) out_if ();

`ifdef PIPE_SKID_STATS_EN
    logic [CW-1:0] stall_count;
`endif

    pipeline_skid_buffer #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .in_if  (in_if),
        .out_if (out_if)
`ifdef PIPE_SKID_STATS_EN
        ,
        .stall_count (stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          in_valid;
        logic [DW-1:0] in_data;
        logic          out_ready;
        logic          flush;
        logic          exp_valid;
        logic [DW-1:0] exp_data;
        logic          exp_ready;
        logic          chk_data;   // out_data is only defined when valid, or right after flush
    } vec_t;

    vec_t vecs[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic iv, input logic [DW-1:0] id, input logic orr, input logic fl,
                       input logic ev, input logic [DW-1:0] ed, input logic er, input logic cd);
        vec_t v;
        v.in_valid  = iv;
        v.in_data   = id;
        v.out_ready = orr;
        v.flush     = fl;
        v.exp_valid = ev;
        v.exp_data  = ed;
        v.exp_ready = er;
        v.chk_data  = cd;
        vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [DW-1:0] id, input logic orr, input logic fl);
        in_if.valid  = iv;
        in_if.data   = id;
        out_if.ready = orr;
        flush        = fl;
    endtask

    initial begin
        rst   = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);

        // ---------------- reset state ----------------
        #2 rst = 1'b0;
        #1;
        check("reset_out_valid", {63'd0, out_if.valid}, 64'd0);
        check("reset_out_data",  out_if.data,           64'd0);
        check("reset_in_ready",  {63'd0, in_if.ready},  64'd1);
        #9 rst = 1'b1;
        step();

        // ---------------- vector table ----------------
        // 1. Streaming 1..8 with downstream always ready: no bubbles, in_ready stays high.
        for (int k = 1; k <= 8; k++)
            add(1'b1, DW'(k), 1'b1, 1'b0, 1'b1, DW'(k), 1'b1, 1'b1);
        add(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0);

        // 2. Backpressure: fill to FULL, 0xA held, extra push refused, then drain in order.
        add(1'b1, 64'hA, 1'b0, 1'b0, 1'b1, 64'hA, 1'b1, 1'b1);
        add(1'b1, 64'hB, 1'b0, 1'b0, 1'b1, 64'hA, 1'b0, 1'b1);
        add(1'b1, 64'hD, 1'b0, 1'b0, 1'b1, 64'hA, 1'b0, 1'b1);
        add(1'b0, '0,    1'b0, 1'b0, 1'b1, 64'hA, 1'b0, 1'b1);
        add(1'b0, '0,    1'b1, 1'b0, 1'b1, 64'hB, 1'b1, 1'b1);
        add(1'b0, '0,    1'b1, 1'b0, 1'b0, '0,    1'b1, 1'b0);

        // 3. Flush while FULL with a pending push of 0xC: everything gone, 0xC dropped.
        add(1'b1, 64'hA, 1'b0, 1'b0, 1'b1, 64'hA, 1'b1, 1'b1);
        add(1'b1, 64'hB, 1'b0, 1'b0, 1'b1, 64'hA, 1'b0, 1'b1);
        add(1'b1, 64'hC, 1'b0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b1);
        add(1'b0, '0,    1'b1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1);

        // 5. BUSY with simultaneous in/out fire for 4 cycles: stays BUSY, order kept.
        add(1'b1, 64'h11, 1'b1, 1'b0, 1'b1, 64'h11, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++)
            add(1'b1, DW'(64'h12 + k), 1'b1, 1'b0, 1'b1, DW'(64'h12 + k), 1'b1, 1'b1);
        add(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0);

        // Flush coinciding with an out_fire: buffer ends empty and zeroed.
        add(1'b1, 64'h20, 1'b0, 1'b0, 1'b1, 64'h20, 1'b1, 1'b1);
        add(1'b0, '0,     1'b1, 1'b1, 1'b0, 64'h0,  1'b1, 1'b1);

        foreach (vecs[i]) begin
            drive(vecs[i].in_valid, vecs[i].in_data, vecs[i].out_ready, vecs[i].flush);
            step();
            check($sformatf("vec%0d_out_valid", i), {63'd0, out_if.valid}, {63'd0, vecs[i].exp_valid});
            check($sformatf("vec%0d_in_ready", i),  {63'd0, in_if.ready},  {63'd0, vecs[i].exp_ready});
            if (vecs[i].chk_data)
                check($sformatf("vec%0d_out_data", i), out_if.data, vecs[i].exp_data);
        end

        // ---------------- 4. reset while FULL ----------------
        drive(1'b1, 64'hA, 1'b0, 1'b0);
        step();
        drive(1'b1, 64'hB, 1'b0, 1'b0);
        step();
        check("full_before_reset_in_ready", {63'd0, in_if.ready}, 64'd0);
        #3 rst = 1'b0;
        #1;
        check("async_reset_out_valid", {63'd0, out_if.valid}, 64'd0);
        check("async_reset_out_data",  out_if.data,           64'd0);
        check("async_reset_in_ready",  {63'd0, in_if.ready},  64'd1);
        // An edge under reset with a live push must not transfer anything.
        drive(1'b1, 64'h77, 1'b1, 1'b0);
        step();
        check("held_reset_out_valid", {63'd0, out_if.valid}, 64'd0);
        rst = 1'b1;
        drive(1'b1, 64'h5, 1'b1, 1'b0);
        step();
        check("post_reset_out_valid", {63'd0, out_if.valid}, 64'd1);
        check("post_reset_out_data",  out_if.data,           64'h5);
        drive(1'b0, '0, 1'b1, 1'b0);
        step();
        check("post_reset_drain_valid", {63'd0, out_if.valid}, 64'd0);

`ifdef PIPE_SKID_STATS_EN
        // ---------------- 6. stall counter saturation ----------------
        #2 rst = 1'b0;
        #2 rst = 1'b1;
        check("stats_reset", {61'd0, stall_count}, 64'd0);
        drive(1'b1, 64'h66, 1'b0, 1'b0);
        step();
        check("stats_after_push", {61'd0, stall_count}, 64'd0);
        drive(1'b0, '0, 1'b0, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            step();
            check($sformatf("stats_cycle%0d", k), {61'd0, stall_count}, (k > 7) ? 64'd7 : 64'(k));
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        step();
        check("stats_hold_after_drain", {61'd0, stall_count}, 64'd7);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pipeline_skid_buffer
